dmem_arbiter: RTL

Two-port arbiter that shares the single synchronous data memory (8-bit address, 32-bit data, one-cycle read latency) between the core load/store path and a debug/loader requester. Sits between the core datapath and the data memory instance, and also serves the program-loader/debug port. Round-robin arbitration per access, with an optional bounded lock for burst ownership and one-cycle read-data routing back to the requester that issued the read.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory (one-cycle read latency)
// between the core load/store path (c_*) and the debug/loader port (d_*).
// Per-access round-robin with an optional bounded burst lock; read data is
// routed back one cycle later to whichever requester issued the read.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make the core win every
// unlocked tie instead of alternating; lock and forced-yield rules are unchanged.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_C = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  localparam logic WIN_CORE  = 1'b0;
  localparam logic WIN_DEBUG = 1'b1;

  localparam int               HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]        state, state_nxt;
  logic              last_winner;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              pend_valid;
  logic              pend_owner;

  logic tie_core;
  logic idle_c, idle_d;
  logic win_c, win_d;
  logic cont_lock;
  logic any_gnt;
  logic win_we, win_lock;

  // Tie-break policy for unlocked arbitration.
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie_core = 1'b1;
`else
  assign tie_core = (last_winner == WIN_DEBUG);
`endif

  assign idle_c = c_req & (~d_req | tie_core);
  assign idle_d = d_req & ~idle_c;

  // Winner selection from requests and the lock state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    win_c     = idle_c;
    win_d     = idle_d;
    cont_lock = 1'b0;
    case (state)
      LOCK_C: begin
        if (c_req && c_lock) begin
          if (hold_cnt < HOLD_MAX || !d_req) begin
            win_c     = 1'b1;
            win_d     = 1'b0;
            cont_lock = 1'b1;
          end else begin
            win_c = 1'b0;
            win_d = 1'b1;
          end
        end
      end
      LOCK_D: begin
        if (d_req && d_lock) begin
          if (hold_cnt < HOLD_MAX || !c_req) begin
            win_c     = 1'b0;
            win_d     = 1'b1;
            cont_lock = 1'b1;
          end else begin
            win_c = 1'b1;
            win_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Grants and memory-side muxing; everything is forced quiet during reset.
  assign c_gnt    = win_c & rst_n;
  assign d_gnt    = win_d & rst_n;
  assign any_gnt  = c_gnt | d_gnt;
  assign win_we   = win_d ? d_we   : c_we;
  assign win_lock = win_d ? d_lock : c_lock;

  assign mem_address = rst_n ? (win_d ? d_addr  : c_addr)  : '0;
  assign mem_data    = rst_n ? (win_d ? d_wdata : c_wdata) : '0;
  assign mem_wren    = any_gnt & win_we;

  // Next lock state and hold count; the cycle that takes the lock counts as
  // the first held cycle, so a locker owns at most MAX_HOLD cycles in a row
  // while the other side waits.
  always_comb begin
    state_nxt = IDLE;
    hold_nxt  = '0;
    if (any_gnt && win_lock) begin
      state_nxt = win_d ? LOCK_D : LOCK_C;
      if (cont_lock)
        hold_nxt = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
      else
        hold_nxt = HOLD_W'(1);
    end
  end

  // Arbitration state and the pending-read owner tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= WIN_DEBUG;
      hold_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_owner  <= WIN_CORE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      pend_valid <= any_gnt & ~win_we;
      if (any_gnt) begin
        last_winner <= win_d;
        pend_owner  <= win_d;
      end
    end
  end

  // Read-data routing: memory output passes straight to the tagged owner.
  assign c_rvalid = pend_valid & (pend_owner == WIN_CORE);
  assign d_rvalid = pend_valid & (pend_owner == WIN_DEBUG);
  assign c_rdata  = c_rvalid ? mem_q : '0;
  assign d_rdata  = d_rvalid ? mem_q : '0;

endmodule
